seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//   Parametrised serial bit-pattern detector; successor to the fixed "0110" Moore detector.
//   - Pattern, length (1..MAX_LEN) and overlap mode are run-time programmable.
//   - Input is qualified by a valid strobe.
//   - Registered Moore-style match flag; optional saturating match counter.
//   - Sits on a serial bit stream between the line deserialiser and the framing logic.
// PARAMETERS
//   MAX_LEN      8        maximum pattern length in bits (>=2)
//   LEN_W        4        width of pat_len; must hold MAX_LEN
//   DEF_PATTERN  8'b0110  pattern after reset (low DEF_LEN bits used)
//   DEF_LEN      4        pattern length after reset
//   DEF_OVERLAP  1        overlap mode after reset (1 = overlapping)
//   CNT_W        8        match counter width
// PORTS
//   clk          in   1        clock; all logic on rising edge
//   reset        in   1        synchronous, active-high reset
//   x_in         in   1        serial data bit
//   in_valid     in   1        x_in sampled only when 1
//   cfg_load     in   1        1-cycle strobe: latch cfg_* and restart detection
//   cfg_pattern  in   MAX_LEN  pattern; bit [len-1] = first bit received, bit [0] = last
//   cfg_len      in   LEN_W    pattern length
//   cfg_overlap  in   1        1 = overlapping matches allowed; 0 = restart after match
//   y_out        out  1        match flag
//   match_count  out  CNT_W    number of matches since reset/cfg_load
// BEHAVIOUR
//   - Reset:
//     - pat <= DEF_PATTERN, len <= DEF_LEN, ovl <= DEF_OVERLAP.
//     - hist <= 0, fill <= 0, y_out <= 0, match_count <= 0.
//   - Accepted bit (in_valid=1, cfg_load=0):
//     - hist <= {hist[MAX_LEN-2:0], x_in}.
//     - fill <= min(fill+1, MAX_LEN); fill counts bits since last restart.
//   - Match: fill_next >= len AND hist_next[len-1:0] == pat[len-1:0].
//   - y_out:
//     - Registered: 1 for exactly the cycle after the edge that accepted the final pattern bit.
//     - 0 in every other cycle, including cycles where in_valid=0.
//     - Latency: 1 clk from the final bit's edge.
//   - ovl=1: history is kept after a match (e.g. 0110110 matches twice).
//   - ovl=0: fill <= 0 on a match; the next match needs len fresh bits.
//   - in_valid=0: hist/fill hold; y_out <= 0.
//   - cfg_load=1:
//     - Latch pattern/len/overlap; hist <= 0, fill <= 0, y_out <= 0, match_count <= 0.
//     - Same-cycle in_valid bit is discarded (cfg_load wins).
//   - Length bounds:
//     - cfg_len > MAX_LEN is clamped to MAX_LEN.
//     - cfg_len == 0 disables detection: y_out stays 0 until the next valid load.
//   - Reset mid-sequence: partial history is discarded; reset has priority over cfg_load and in_valid.
//   - Pattern bits above len are ignored.
// CONFIGURATION
//   MATCH_COUNT_EN defined:
//     - match_count increments on each match; updates in the same cycle y_out asserts.
//     - Saturates at 2^CNT_W-1; never wraps.
//   MATCH_COUNT_EN undefined:
//     - No counter register; match_count tied to 0.
//     - y_out behaviour is identical.
// TESTING
//   1 Reset held 2 cycles, any x_in -> y_out=0, match_count=0, defaults in force.
//   2 Defaults, in_valid=1, stream 0110110 -> y_out=1 after bit 4 and after bit 7; count=2.
//   3 cfg_load overlap=0, len=4, pat=0110; stream 0110110 -> single y_out pulse after bit 4; count=1.
//   4 cfg_load pat=101, len=3, ovl=1; stream 1,0,(in_valid=0 for 3 cycles),1,0,1 -> y_out after bits 3 and 5 only; y_out=0 during gap.
//   5 MATCH_COUNT_EN, CNT_W=2, defaults, 5 separate 0110 matches -> count 1,2,3,3,3 (saturates).
//   6 Stream 011, reset, then 0 -> no y_out; cfg_load with cfg_len=0 then 0110 -> y_out stays 0.

Source files
------------

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_param
// Description : Run-time programmable serial pattern detector with registered
//               match flag; optional saturating match counter (MATCH_COUNT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = 4,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0110),
    parameter int                 DEF_LEN     = 4,
    parameter bit                 DEF_OVERLAP = 1'b1,
    parameter int                 CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x_in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               y_out,
    output logic [CNT_W-1:0]   match_count
);

    localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               y_q, y_d;

    logic [MAX_LEN-1:0] w_hist_acc;
    logic [LEN_W-1:0]   w_fill_acc;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_hit;

    always_comb begin
        w_hist_acc = {hist_q[MAX_LEN-2:0], x_in};
        w_fill_acc = (fill_q >= C_MAX_LEN) ? fill_q : fill_q + LEN_W'(1);
        w_mask     = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(len_q));
        end
        // A zero length never matches, so detection stays off until reloaded.
        w_hit = (len_q != '0) && (w_fill_acc >= len_q) &&
                (((w_hist_acc ^ pat_q) & w_mask) == '0);
    end

    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        y_d    = 1'b0;
        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = (cfg_len > C_MAX_LEN) ? C_MAX_LEN : cfg_len;
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = w_hist_acc;
            fill_d = (w_hit && !ovl_q) ? '0 : w_fill_acc;
            y_d    = w_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q  <= DEF_PATTERN;
            len_q  <= LEN_W'(DEF_LEN);
            ovl_q  <= DEF_OVERLAP;
            hist_q <= '0;
            fill_q <= '0;
            y_q    <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            y_q    <= y_d;
        end
    end

    assign y_out = y_q;

`ifdef MATCH_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cfg_load) begin
            cnt_d = '0;
        end else if (y_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_count = cnt_q;
`else
    assign match_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detector_param
// Description : Directed self-checking bench for seq_detector_param.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               x_in;
    logic               in_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               y_out;
    logic [CNT_W-1:0]   match_count;

    int n_cmp = 0;
    int n_err = 0;

    seq_detector_param #(
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .x_in       (x_in),
        .in_valid   (in_valid),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .y_out      (y_out),
        .match_count(match_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected counter value after n matches (counter tied low when disabled).
    function automatic int exp_cnt(input int n);
`ifdef MATCH_COUNT_EN
        return (n > 3) ? 3 : n;
`else
        return 0;
`endif
    endfunction

    // Bits applied MSB first; exp[i] is the y_out expected after bit i.
    task automatic stream(input string tag, input logic [15:0] bits,
                          input int n, input logic [15:0] exp);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            x_in     = bits[i];
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("%s_b%0d", tag, n - i), y_out, exp[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            x_in     = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("%s_idle%0d", tag, i), y_out, 0);
        end
    endtask

    // Same-cycle valid bit is presented to confirm the load discards it.
    task automatic load(input string tag, input logic [MAX_LEN-1:0] pat,
                        input logic [LEN_W-1:0] len, input logic ovl);
        @(negedge clk);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        in_valid    = 1'b1;
        x_in        = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_load_y"}, y_out, 0);
        check({tag, "_load_cnt"}, match_count, 0);
        @(negedge clk);
        cfg_load = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        x_in        = 1'b0;
        in_valid    = 1'b1;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;

        // Reset held two cycles with live input.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            x_in = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("rst_y", y_out, 0);
            check("rst_cnt", match_count, 0);
        end
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;

        // Default 0110 overlapping: matches after bits 4 and 7.
        stream("def_ovl", 16'b0110110, 7, 16'b0001001);
        check("def_ovl_cnt", match_count, exp_cnt(2));

        // Non-overlapping: only the first match.
        load("novl", 8'b0000_0110, 4'd4, 1'b0);
        stream("novl", 16'b0110110, 7, 16'b0001000);
        check("novl_cnt", match_count, exp_cnt(1));

        // 101 with junk above len, and an in_valid gap mid-stream.
        load("p101", 8'b1100_0101, 4'd3, 1'b1);
        stream("p101a", 16'b10, 2, 16'b00);
        idle("p101", 3);
        stream("p101b", 16'b101, 3, 16'b101);
        check("p101_cnt", match_count, exp_cnt(2));

        // Five separate matches drive the 2-bit counter into saturation.
        load("sat", 8'b0000_0110, 4'd4, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            stream($sformatf("sat%0d", k), 16'b0110, 4, 16'b0001);
            check($sformatf("sat_cnt%0d", k), match_count, exp_cnt(k));
        end

        // Oversize length clamps to MAX_LEN.
        load("clamp", 8'b1010_1010, 4'd15, 1'b1);
        stream("clamp", 16'b1010101010, 10, 16'b0000000101);
        check("clamp_cnt", match_count, exp_cnt(2));

        // Reset mid-sequence discards history and restores defaults.
        stream("pre_rst", 16'b011, 3, 16'b000);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_y", y_out, 0);
        check("midrst_cnt", match_count, 0);
        @(negedge clk);
        reset = 1'b0;
        stream("post_rst", 16'b0110, 4, 16'b0001);
        check("post_rst_cnt", match_count, exp_cnt(1));

        // Zero length disables detection.
        load("len0", 8'b0000_0110, 4'd0, 1'b1);
        stream("len0", 16'b0110, 4, 16'b0000);
        check("len0_cnt", match_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
